btb_update_unit: RTL and testbench
==================================

Name: btb_update_unit

Overview:
- Write side of the branch target buffer: owns the tagged BTB/BHT storage.
- The EX stage presents resolved branch/jump outcomes to this block. It detects a mispredict, drives the redirect PC, and writes back the target and a 2-bit saturating counter.
- A combinational lookup port serves the IF stage.
- After reset, an invalidate sweep clears the table, one entry per cycle, before the block accepts lookups or updates.

Parameters:
- ENTRIES, 32, number of BTB entries; must be a power of two.
- INDEX_BITS, 5, log2(ENTRIES); tag width is 30-INDEX_BITS (localparam).
- CNT_INIT, 2'b10, counter value given to a newly allocated conditional-branch entry.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- if_pc  input  32  fetch PC for lookup.
- pred_hit  output  1  valid entry with matching tag.
- pred_taken  output  1  pred_hit & counter[1].
- next_pc  output  32  stored target if pred_taken, else if_pc+4.
- ex_valid  input  1  resolved control instruction present in EX this cycle.
- ex_is_jump  input  1  unconditional (JAL/JALR); 0 = conditional branch.
- ex_pc  input  32  PC of the resolved instruction.
- ex_taken  input  1  actual direction; tied to 1 by the caller when ex_is_jump=1.
- ex_target  input  32  actual target.
- ex_pred_taken  input  1  prediction carried down the pipeline.
- ex_pred_target  input  32  predicted next PC carried down the pipeline.
- mispredict  output  1  combinational flush request.
- redirect_pc  output  32  correct next PC.
- init_busy  output  1  invalidate sweep in progress.
- mispredict_count  output  32  saturating mispredict counter.

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2]
  - pc[1:0] is ignored.
- FSM states: INIT and READY.
  - Async reset forces INIT, sweep pointer to 0, and mispredict_count to 0.
  - INIT clears valid[ptr] every cycle. When ptr=ENTRIES-1 it moves to READY on that edge, so the sweep takes exactly ENTRIES cycles.
  - init_busy = (state==INIT).
  - Reset asserted mid-sweep or mid-operation restarts the sweep from 0.
- Lookup (combinational, from current array contents):
  - In INIT, pred_hit=0 and next_pc=if_pc+4.
  - A same-cycle update to the same index is not visible until the following cycle; the lookup reads the pre-write contents.
- Mispredict:
  - mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4 (32-bit wrap).
  - Both outputs are valid in INIT as well; only the table write is suppressed.
- Update (registered, on the clk edge, READY and ex_valid only):
  - Tag hit, conditional branch: counter += 1 if ex_taken, else -= 1, saturating at 3 and 0. Target overwritten with ex_target when ex_taken.
  - Tag hit, jump: counter=3, target=ex_target.
  - Tag miss and ex_taken: allocate (replace). valid=1, tag written, target=ex_target, counter = jump ? 3 : CNT_INIT.
  - Tag miss and not taken: no write.
- mispredict_count:
  - Increments on every clk edge where mispredict=1, including during INIT.
  - Saturates at 32'hFFFF_FFFF.
- Output reset values:
  - init_busy=1 and mispredict_count=0.
  - pred_hit=0 and next_pc=if_pc+4 (because the state is INIT).
  - mispredict and redirect_pc follow their inputs combinationally.

Test Plan:
1. Sweep: assert reset, release it, present if_pc=0x100 -> init_busy=1 for exactly 32 cycles, then 0. pred_hit=0 and next_pc=0x104 throughout.
2. Allocate and hit:
   - Stimulus: after init, ex_valid=1, ex_pc=0x40, branch, ex_taken=1, ex_target=0x80, ex_pred_taken=0.
   - Expect mispredict=1 and redirect_pc=0x80.
   - Next cycle with if_pc=0x40: pred_hit=1, pred_taken=1 (counter 2), next_pc=0x80.
3. Saturation: on 0x40, apply three not-taken updates -> counter 1 then 0 then 0. pred_taken=0, next_pc=0x44, pred_hit=1. Each not-taken update against a taken prediction flags mispredict.
4. Aliasing: update a taken jump at 0xC0 (same index as 0x40, different tag), target 0x200 -> lookup 0x40 gives pred_hit=0. Lookup 0xC0 gives pred_taken=1 and next_pc=0x200.
5. Read-during-write: same-cycle update 0x40 (target 0x300) and if_pc=0x40 -> next_pc shows the old value that cycle and 0x300 the next cycle.
6. Correct prediction: ex_pred_taken=1, ex_pred_target=0x300, ex_taken=1, ex_target=0x300 -> mispredict=0 and mispredict_count unchanged. Then reset mid-sweep at cycle 10 -> sweep restarts and count returns to 0.

Source files
------------

// File: rtl/btb_update_unit.sv
// Branch target buffer write side with a combinational fetch lookup port.
// Owns the tagged target / 2-bit counter storage, flags mispredicts coming
// out of EX, and clears the table with a one-entry-per-cycle sweep after reset.
module btb_update_unit #(
    parameter int         ENTRIES    = 32,
    parameter int         INDEX_BITS = 5,
    parameter logic [1:0] CNT_INIT   = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] next_pc,
    input  logic        ex_valid,
    input  logic        ex_is_jump,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        init_busy,
    output logic [31:0] mispredict_count
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_PTR = INDEX_BITS'(ENTRIES - 1);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [INDEX_BITS-1:0] ptr;
    logic [INDEX_BITS-1:0] ptr_next;

    logic                  valid_mem  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
    logic [31:0]           target_mem [ENTRIES];
    logic [1:0]            cnt_mem    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;
    logic                  ex_hit;

    logic                  wr_en;
    logic [1:0]            wr_cnt;
    logic [31:0]           wr_target;

    assign if_idx    = if_pc[INDEX_BITS+1:2];
    assign if_tag    = if_pc[31:INDEX_BITS+2];
    assign ex_idx    = ex_pc[INDEX_BITS+1:2];
    assign ex_tag    = ex_pc[31:INDEX_BITS+2];
    assign init_busy = (state == INIT);

    // State and sweep pointer register; reset restarts the sweep from entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Sweep walks every entry once, then the table stays READY until reset.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            INIT: begin
                ptr_next = ptr + INDEX_BITS'(1);
                if (ptr == LAST_PTR) begin
                    state_next = READY;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // Fetch lookup reads the current (pre-write) contents; nothing hits while sweeping.
    always_comb begin
        pred_hit   = (state == READY) && valid_mem[if_idx] && (tag_mem[if_idx] == if_tag);
        pred_taken = pred_hit && cnt_mem[if_idx][1];
        next_pc    = pred_taken ? target_mem[if_idx] : (if_pc + 32'd4);
    end

    // Mispredict detection and the correct next PC, live even while sweeping.
    always_comb begin
        mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
    end

    // Decide what, if anything, the resolved instruction writes into its entry.
    always_comb begin
        ex_hit    = valid_mem[ex_idx] && (tag_mem[ex_idx] == ex_tag);
        wr_en     = 1'b0;
        wr_cnt    = cnt_mem[ex_idx];
        wr_target = target_mem[ex_idx];
        if ((state == READY) && ex_valid) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (ex_is_jump) begin
                    wr_cnt    = 2'b11;
                    wr_target = ex_target;
                end else if (ex_taken) begin
                    wr_cnt    = (cnt_mem[ex_idx] == 2'b11) ? 2'b11 : cnt_mem[ex_idx] + 2'b01;
                    wr_target = ex_target;
                end else begin
                    wr_cnt    = (cnt_mem[ex_idx] == 2'b00) ? 2'b00 : cnt_mem[ex_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                wr_en     = 1'b1;
                wr_cnt    = ex_is_jump ? 2'b11 : CNT_INIT;
                wr_target = ex_target;
            end
        end
    end

    // Table storage: sweep clears one valid bit per cycle, otherwise apply the update.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            valid_mem[ptr] <= 1'b0;
        end else if (wr_en) begin
            valid_mem[ex_idx]  <= 1'b1;
            tag_mem[ex_idx]    <= ex_tag;
            target_mem[ex_idx] <= wr_target;
            cnt_mem[ex_idx]    <= wr_cnt;
        end
    end

    // Saturating count of every cycle that raised a flush request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_count <= '0;
        end else if (mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
            mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_btb_update_unit.sv
// Directed testbench for btb_update_unit: sweep, allocate/hit, counter
// saturation, aliasing, read-during-write, correct prediction and reset restart.
module tb_btb_update_unit;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic        ex_valid;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        init_busy;
    logic [31:0] mispredict_count;

    int checkCount;
    int errorCount;

    btb_update_unit dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .next_pc          (next_pc),
        .ex_valid         (ex_valid),
        .ex_is_jump       (ex_is_jump),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .init_busy        (init_busy),
        .mispredict_count (mispredict_count)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one EX-stage vector plus fetch PC, then let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic jmp, input logic [31:0] pc,
                                 input logic tk, input logic [31:0] tgt,
                                 input logic ptk, input logic [31:0] ptgt,
                                 input logic [31:0] fpc);
        ex_valid       = v;
        ex_is_jump     = jmp;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        if_pc          = fpc;
        #1;
    endtask

    task automatic idleStimulus(input logic [31:0] fpc);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, fpc);
    endtask

    // Release reset on a falling edge and check init_busy lasts exactly 32 cycles.
    task automatic checkSweep(input string tag);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idleStimulus(32'h100);
            checkOutput({tag, "_busy"}, 32'(init_busy), 32'd1);
            if (i == 0 || i == 31) begin
                checkOutput({tag, "_hit"}, 32'(pred_hit), 32'd0);
                checkOutput({tag, "_npc"}, next_pc, 32'h104);
            end
            @(negedge clk);
        end
        idleStimulus(32'h100);
        checkOutput({tag, "_done"}, 32'(init_busy), 32'd0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        idleStimulus(32'h100);

        // Reset state
        @(negedge clk);
        idleStimulus(32'h100);
        checkOutput("rst_busy", 32'(init_busy), 32'd1);
        checkOutput("rst_cnt", mispredict_count, 32'd0);
        checkOutput("rst_hit", 32'(pred_hit), 32'd0);
        checkOutput("rst_npc", next_pc, 32'h104);
        checkOutput("rst_misp", 32'(mispredict), 32'd0);

        // 1. Sweep
        checkSweep("sweep1");

        // 2. Allocate branch at 0x40 -> 0x80
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 32'h40);
        checkOutput("alloc_misp", 32'(mispredict), 32'd1);
        checkOutput("alloc_redir", redirect_pc, 32'h80);
        checkOutput("alloc_rdw_hit", 32'(pred_hit), 32'd0);
        @(negedge clk);
        idleStimulus(32'h40);
        checkOutput("hit_hit", 32'(pred_hit), 32'd1);
        checkOutput("hit_taken", 32'(pred_taken), 32'd1);
        checkOutput("hit_npc", next_pc, 32'h80);
        checkOutput("hit_cnt", mispredict_count, 32'd1);

        // 3. Three not-taken updates: counter 2 -> 1 -> 0 -> 0
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 32'h40);
        checkOutput("nt1_misp", 32'(mispredict), 32'd1);
        checkOutput("nt1_redir", redirect_pc, 32'h44);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 32'h40);
        checkOutput("nt2_misp", 32'(mispredict), 32'd1);
        checkOutput("nt2_taken", 32'(pred_taken), 32'd0);
        checkOutput("nt2_npc", next_pc, 32'h44);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 32'h40);
        checkOutput("nt3_misp", 32'(mispredict), 32'd1);
        @(negedge clk);
        idleStimulus(32'h40);
        checkOutput("sat0_hit", 32'(pred_hit), 32'd1);
        checkOutput("sat0_taken", 32'(pred_taken), 32'd0);
        checkOutput("sat0_npc", next_pc, 32'h44);
        checkOutput("sat0_cnt", mispredict_count, 32'd4);

        // 4. Aliasing jump at 0xC0 replaces the 0x40 entry
        applyStimulus(1'b1, 1'b1, 32'hC0, 1'b1, 32'h200, 1'b0, 32'hC4, 32'h40);
        checkOutput("alias_misp", 32'(mispredict), 32'd1);
        @(negedge clk);
        idleStimulus(32'h40);
        checkOutput("alias_40_hit", 32'(pred_hit), 32'd0);
        checkOutput("alias_40_npc", next_pc, 32'h44);
        idleStimulus(32'hC0);
        checkOutput("alias_C0_taken", 32'(pred_taken), 32'd1);
        checkOutput("alias_C0_npc", next_pc, 32'h200);
        // Not-taken branch on the jump entry: counter 3 -> 2, target kept
        applyStimulus(1'b1, 1'b0, 32'hC0, 1'b0, 32'h999, 1'b1, 32'h200, 32'hC0);
        checkOutput("c0nt_redir", redirect_pc, 32'hC4);
        @(negedge clk);
        idleStimulus(32'hC0);
        checkOutput("c0nt_taken", 32'(pred_taken), 32'd1);
        checkOutput("c0nt_npc", next_pc, 32'h200);
        checkOutput("c0nt_cnt", mispredict_count, 32'd6);

        // 5. Read-during-write at 0x40 -> 0x300
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44, 32'h40);
        checkOutput("rdw_old_npc", next_pc, 32'h44);
        checkOutput("rdw_old_hit", 32'(pred_hit), 32'd0);
        @(negedge clk);
        idleStimulus(32'h40);
        checkOutput("rdw_new_hit", 32'(pred_hit), 32'd1);
        checkOutput("rdw_new_npc", next_pc, 32'h300);

        // 6. Correct prediction leaves the count alone
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b1, 32'h300, 1'b1, 32'h300, 32'h40);
        checkOutput("ok_misp", 32'(mispredict), 32'd0);
        checkOutput("ok_redir", redirect_pc, 32'h300);
        @(negedge clk);
        idleStimulus(32'h40);
        checkOutput("ok_cnt", mispredict_count, 32'd7);
        // Wrong target with matching direction is a mispredict
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b1, 32'h300, 1'b1, 32'h304, 32'h40);
        checkOutput("tgt_misp", 32'(mispredict), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b1, 32'h300, 1'b0, 32'h304, 32'h40);
        checkOutput("novalid_misp", 32'(mispredict), 32'd0);

        // Reset, then count mispredicts during the sweep and reset again at cycle 10
        reset = 1'b1;
        #1;
        checkOutput("areset_cnt", mispredict_count, 32'd0);
        checkOutput("areset_busy", 32'(init_busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 2) begin
                applyStimulus(1'b1, 1'b0, 32'h40, 1'b1, 32'h500, 1'b0, 32'h44, 32'h40);
            end else begin
                idleStimulus(32'h40);
            end
            @(negedge clk);
        end
        idleStimulus(32'h40);
        checkOutput("init_cnt", mispredict_count, 32'd2);
        checkOutput("init_busy10", 32'(init_busy), 32'd1);
        checkOutput("init_hit", 32'(pred_hit), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("mid_cnt", mispredict_count, 32'd0);
        @(negedge clk);
        checkSweep("sweep2");
        idleStimulus(32'h40);
        checkOutput("cleared_hit", 32'(pred_hit), 32'd0);
        checkOutput("cleared_npc", next_pc, 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
